// File: rtl/btn_conditioner_pkg.sv
// Shared types and 48 MHz defaults for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } btn_state_e;

    localparam bit          DefActiveLow       = 1'b1;
    localparam int unsigned DefDebounceCycles  = 480000;    // 10 ms
    localparam int unsigned DefLongPressCycles = 96000000;  // 2 s
    localparam int unsigned DefRstPulseCycles  = 16;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button pad input and conditioned outputs; master is the conditioner side.
interface btn_conditioner_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic rst_req_n;

    modport master (
        input  btn_raw,
        output btn_level, press_pulse, release_pulse, long_pulse, rst_req_n
    );

    modport slave (
        output btn_raw,
        input  btn_level, press_pulse, release_pulse, long_pulse, rst_req_n
    );
endinterface

// File: rtl/btn_conditioner_sync2.sv
// Two-flop synchroniser for an asynchronous pad input, reset to RstVal.
module sync2 #(
    parameter logic RstVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic s1_q, s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= RstVal;
            s2_q <= RstVal;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: sync, debounce, press/release strobes.
// Long-press detect and reset-request pulse exist only with BTNC_LONG_PRESS_EN defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter bit          ACTIVE_LOW        = DefActiveLow,
    parameter int unsigned DEBOUNCE_CYCLES   = DefDebounceCycles,
    parameter int unsigned LONG_PRESS_CYCLES = DefLongPressCycles,
    parameter int unsigned RST_PULSE_CYCLES  = DefRstPulseCycles
) (
    input logic               clk,
    input logic               rst,
    btn_conditioner_if.master bus
);
    localparam int unsigned     DebW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);

    logic            btn_sync;
    logic            p;
    btn_state_e      state_q, state_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    sync2 #(
        .RstVal(1'(ACTIVE_LOW))
    ) u_sync2 (
        .clk(clk),
        .rst(rst),
        .d_i(bus.btn_raw),
        .q_o(btn_sync)
    );

    assign p = btn_sync ^ ACTIVE_LOW;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (p) begin
                    state_d   = PRESS_PEND;
                    deb_cnt_d = DebW'(1);
                end
            end
            PRESS_PEND: begin
                if (!p) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                    level_d   = 1'b1;
                    press_d   = 1'b1;
                end else if (deb_cnt_q < DebLast) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_d   = RELEASE_PEND;
                    deb_cnt_d = DebW'(1);
                end
            end
            RELEASE_PEND: begin
                if (p) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else if (deb_cnt_q < DebLast) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RELEASED;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;

`ifdef BTNC_LONG_PRESS_EN
    localparam int unsigned      HoldW   = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int unsigned      RstW    = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_PRESS_CYCLES);

    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
    logic             long_q;
    logic             rst_req_n_q;
    logic             holding;
    logic             fire;

    // Hold timer runs through release bounces; only a new accepted press clears it.
    assign holding = (state_q == PRESSED) || (state_q == RELEASE_PEND);
    assign fire    = holding && (hold_cnt_q == HoldW'(LONG_PRESS_CYCLES - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        if ((state_q == PRESS_PEND) && (state_d == PRESSED)) begin
            hold_cnt_d = '0;
        end else if (holding && (hold_cnt_q < HoldMax)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (fire) begin
            rst_cnt_d = RstW'(RST_PULSE_CYCLES);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q  <= '0;
            rst_cnt_q   <= '0;
            long_q      <= 1'b0;
            rst_req_n_q <= 1'b1;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            long_q      <= fire;
            rst_req_n_q <= (rst_cnt_d == '0);
        end
    end

    assign bus.long_pulse = long_q;
    assign bus.rst_req_n  = rst_req_n_q;
`else
    assign bus.long_pulse = 1'b0;
    assign bus.rst_req_n  = 1'b1;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner against a run-length debounce model.
module tb_btn_conditioner;
    localparam bit          AL   = 1'b1;
    localparam int unsigned DEB  = 8;
    localparam int unsigned LONG = 50;
    localparam int unsigned RSTP = 4;
    localparam logic        RL   = AL;   // raw level when released
    localparam logic        PR   = !AL;  // raw level when pressed

    typedef struct {
        int kind;  // 0 press, 1 release, 2 long
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    btn_conditioner_if bus_if ();

    btn_conditioner #(
        .ACTIVE_LOW       (AL),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .RST_PULSE_CYCLES (RSTP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    ev_t  sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic hist[$];
    logic m_level = 1'b0;
    int   m_run = 0;
    int   m_hold = 0;
    int   m_rst_left = 0;
    int   long_seen = 0;
    int   rstn_low_seen = 0;
    logic [2:0] pulses;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: level flips after DEB consecutive samples that disagree with it;
    // samples are the raw pad two clocks late.
    initial begin
        hist = '{RL, RL};
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist       = '{RL, RL};
                m_level    = 1'b0;
                m_run      = 0;
                m_hold     = 0;
                m_rst_left = 0;
                sb.delete();
            end else begin
                logic pv;
                logic was;
                cyc++;
                pv = hist.pop_front() ^ AL;
                hist.push_back(bus_if.btn_raw);
                was = m_level;
                if (pv != m_level) m_run++;
                else m_run = 0;
                if (m_run == DEB) begin
                    m_level = pv;
                    m_run   = 0;
                    sb.push_back('{pv ? 0 : 1, cyc});
                end
`ifdef BTNC_LONG_PRESS_EN
                if (m_rst_left > 0) m_rst_left--;
                if (was && m_hold < LONG) begin
                    m_hold++;
                    if (m_hold == LONG) begin
                        sb.push_back('{2, cyc});
                        m_rst_left = RSTP;
                    end
                end
                if (!was && m_level) m_hold = 0;
`endif
            end
        end
    end

    // Monitor: pops expected strobes as the DUT presents them.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                check("btn_level", bus_if.btn_level, m_level);
                check("rst_req_n", bus_if.rst_req_n, (m_rst_left == 0) ? 1 : 0);
                check("pulse_overlap", bus_if.press_pulse & bus_if.release_pulse, 0);
                pulses = {bus_if.long_pulse, bus_if.release_pulse, bus_if.press_pulse};
                if (bus_if.long_pulse) long_seen++;
                if (!bus_if.rst_req_n) rstn_low_seen++;
                for (int k = 0; k < 3; k++) begin
                    if (pulses[k]) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected",
                                     k, cyc);
                        end else begin
                            ev_t e;
                            e = sb.pop_front();
                            check("pulse_kind", k, e.kind);
                            check("pulse_cycle", cyc, e.cyc);
                        end
                    end
                end
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_pulse: kind %0d due cycle %0d, now %0d",
                             sb[0].kind, sb[0].cyc, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(logic v, int n);
        bus_if.btn_raw = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        #1;
        check({tag, "_level"}, bus_if.btn_level, 0);
        check({tag, "_press"}, bus_if.press_pulse, 0);
        check({tag, "_release"}, bus_if.release_pulse, 0);
        check({tag, "_long"}, bus_if.long_pulse, 0);
        check({tag, "_rstn"}, bus_if.rst_req_n, 1);
    endtask

    // Edge at a negedge, then count negedges until the strobe shows; bounded.
    task automatic measure(string name, logic v, bit rel, int hold);
        int n;
        n = 0;
        bus_if.btn_raw = v;
        while (n < 40 && !(rel ? bus_if.release_pulse : bus_if.press_pulse)) begin
            @(negedge clk);
            n++;
        end
        check(name, n, 2 + DEB);
        if (n < hold) repeat (hold - n) @(negedge clk);
    endtask

    task automatic long_hold(string tag);
        int exp_long;
        int exp_low;
`ifdef BTNC_LONG_PRESS_EN
        exp_long = 1;
        exp_low  = RSTP;
`else
        exp_long = 0;
        exp_low  = 0;
`endif
        long_seen     = 0;
        rstn_low_seen = 0;
        drive(PR, 100);
        drive(RL, 30);
        check({tag, "_long_count"}, long_seen, exp_long);
        check({tag, "_rstn_low_cycles"}, rstn_low_seen, exp_low);
    endtask

    initial begin
        bus_if.btn_raw = RL;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        drive(RL, 20);

        // Reset asserted while a press is pending
        drive(PR, 6);
        rst = 1'b1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        bus_if.btn_raw = RL;
        @(negedge clk);
        rst = 1'b0;
        drive(RL, 20);

        measure("press_latency", PR, 1'b0, 20);

        drive(RL, 4);
        drive(PR, 2);
        measure("release_latency", RL, 1'b1, 20);

        for (int i = 0; i < 4; i++) begin
            drive(PR, 5);
            drive(RL, 3);
        end
        drive(RL, 20);
        check("bounce_level", bus_if.btn_level, 0);

        long_hold("hold1");
        long_hold("hold2");

        // Long press, then reset during the reset-request pulse
        drive(PR, 2 + DEB + LONG + 2);
        rst = 1'b1;
        check_reset_outputs("pulse_rst");
        @(negedge clk);
        bus_if.btn_raw = RL;
        @(negedge clk);
        rst = 1'b0;
        drive(RL, 20);

        for (int i = 0; i < 60; i++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 80) : $urandom_range(1, 14);
            drive(v, len);
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                check_reset_outputs("rand_rst");
                @(negedge clk);
                rst = 1'b0;
            end
        end
        drive(RL, 40);
        check("scoreboard_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
